cci_mpf_prim_rr_merge: RTL and testbench
========================================

# cci_mpf_prim_rr_merge

Packet-aware round-robin merge stage. It consumes the head of N_INPUTS upstream two-entry FIFOs (first/notEmpty/deq_en) and enqueues one beat per cycle into a single downstream two-entry FIFO (enq_data/enq_en/notFull). Multi-beat packets are never interleaved: a grant is held from the first beat through the end-of-packet beat. The datapath is combinational and the arbitration state is registered, so the merge adds zero cycles between upstream and downstream buffers.

## Interface
- N_INPUTS, 2: number of upstream sources; ≥2; non-power-of-2 supported.
- N_DATA_BITS, 32: beat payload width, excluding eop.
- N_SRC_BITS, $clog2(N_INPUTS): width of the source index.

- clk  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-high reset.
- in_first  in  [N_INPUTS][N_DATA_BITS]  head beat of each upstream FIFO.
- in_eop  in  [N_INPUTS]  head beat is last of its packet.
- in_notEmpty  in  [N_INPUTS]  upstream head valid.
- in_deq_en  out  [N_INPUTS]  dequeue upstream head this cycle; one-hot or zero.
- out_enq_data  out  N_DATA_BITS  forwarded beat.
- out_eop  out  1  forwarded beat is end of packet.
- out_src  out  N_SRC_BITS  index of granted input.
- out_enq_en  out  1  enqueue into downstream FIFO this cycle.
- out_notFull  in  1  downstream FIFO can accept a beat.

## Operation
- State: mode ∈ {IDLE, LOCKED}; rr_ptr (N_SRC_BITS); lock_idx (N_SRC_BITS).
- IDLE: candidate = first index i, scanning rr_ptr, rr_ptr+1, …, wrapping modulo N_INPUTS, with in_notEmpty[i]=1. No candidate → no transfer.
- LOCKED: candidate = lock_idx only, regardless of other inputs.
- Transfer fires when a candidate exists, its in_notEmpty=1 and out_notFull=1: out_enq_en=1, in_deq_en[candidate]=1, out_enq_data/out_eop/out_src from candidate.
- No transfer: out_enq_en=0, in_deq_en all 0. out_enq_data/out_eop/out_src still reflect the candidate (don't-care when out_enq_en=0).
- On transfer with eop=0: mode←LOCKED, lock_idx←candidate. Covers both the IDLE start and LOCKED continuation.
- On transfer with eop=1: mode←IDLE, rr_ptr←(candidate+1) mod N_INPUTS. Wrap rule: candidate=N_INPUTS-1 → 0.
- rr_ptr does not change while LOCKED or on idle cycles.
- Single-beat packet (eop=1 on the first beat): stays IDLE; rr_ptr advances.
- LOCKED with empty lock_idx input (bubble mid-packet): hold the grant and wait. No other input may transfer.
- out_notFull=0: no state change. Candidate selection is recomputed next cycle, so a higher-priority arrival in IDLE may win.
- Reset (including mid-packet): mode←IDLE, rr_ptr←0, lock_idx←0. A partial packet is abandoned at the merge; recovery is the caller's responsibility.
- Simulation assertions (outside reset):
  - in_deq_en[i] implies in_notEmpty[i].
  - out_enq_en implies out_notFull.
  - in_deq_en is one-hot or zero.

## Timing
- Zero-cycle latency: in_notEmpty/in_first/out_notFull → out_enq_en/in_deq_en/out_enq_data is combinational. Both neighbours register their own storage, so there is no combinational loop.
- Throughput: one beat per cycle sustained when the granted source and the downstream FIFO keep up. Back-to-back packets from different sources switch with no bubble.
- Outputs during reset cycle: in_deq_en=0, out_enq_en=0. Thereafter they follow the rules above using post-reset state (IDLE, rr_ptr=0).
- State updates take effect on the posedge after the transfer cycle.
- The arbitration decision depends only on registered state plus current-cycle inputs.

## Test plan
- N_INPUTS=4, all inputs hold single-beat packets continuously, out_notFull=1 → out_src sequence 0,1,2,3,0,1,… with one beat per cycle.
- Input 1 sends a 3-beat packet (eop on beat 3) while inputs 0 and 2 are non-empty → out_src=1 for 3 consecutive transfers, no interleave; next grant = 2, then 0.
- Input 0 sends a packet with notEmpty low for 2 cycles between beats 1 and 2, input 3 non-empty → no transfers during the bubble; input 3 is granted only after input 0's eop.
- out_notFull toggles 1,0,1,0 with all inputs full → transfers only on out_notFull=1 cycles; no beat lost or duplicated; round-robin order preserved.
- N_INPUTS=3, only input 2 active with single-beat packets → rr_ptr wraps 2→0; input 2 is granted every cycle.
- Reset asserted mid-packet on input 1 (LOCKED) → next cycle IDLE, rr_ptr=0; input 0 is granted first if non-empty.

Source files
------------

// File: rtl/cci_mpf_prim_rr_merge_if.sv
// Handshake bundle between N upstream FIFO heads, the merge stage and one downstream FIFO.
// The master modport is the merge's view of it; slave is the surrounding FIFOs' view.
interface cci_mpf_prim_rr_merge_if #(
  parameter int N_INPUTS    = 2,
  parameter int N_DATA_BITS = 32,
  parameter int N_SRC_BITS  = $clog2(N_INPUTS)
);
  logic [N_INPUTS-1:0][N_DATA_BITS-1:0] in_first;
  logic [N_INPUTS-1:0]                  in_eop;
  logic [N_INPUTS-1:0]                  in_notEmpty;
  logic [N_INPUTS-1:0]                  in_deq_en;
  logic [N_DATA_BITS-1:0]               out_enq_data;
  logic                                 out_eop;
  logic [N_SRC_BITS-1:0]                out_src;
  logic                                 out_enq_en;
  logic                                 out_notFull;

  modport master (
    input  in_first, in_eop, in_notEmpty, out_notFull,
    output in_deq_en, out_enq_data, out_eop, out_src, out_enq_en
  );

  modport slave (
    output in_first, in_eop, in_notEmpty, out_notFull,
    input  in_deq_en, out_enq_data, out_eop, out_src, out_enq_en
  );
endinterface

// File: rtl/cci_mpf_prim_rr_merge.sv
// Packet-aware round-robin merge: combinational datapath and registered arbitration state.
// A grant is held from a packet's first beat through its eop beat, so packets never interleave.
module cci_mpf_prim_rr_merge #(
  parameter int N_INPUTS    = 2,
  parameter int N_DATA_BITS = 32,
  parameter int N_SRC_BITS  = $clog2(N_INPUTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  cci_mpf_prim_rr_merge_if.master bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mode_t;

  mode_t                 mode;
  logic [N_SRC_BITS-1:0] rr_ptr;
  logic [N_SRC_BITS-1:0] lock_idx;

  logic [N_SRC_BITS-1:0] cand;
  logic                  found;
  logic                  fire;
  logic                  cand_eop;
  logic [N_SRC_BITS-1:0] next_ptr;
  int                    scan_idx;

  // In IDLE scan from rr_ptr with wraparound; in LOCKED only the owning input may proceed.
  always_comb begin
    cand     = rr_ptr;
    found    = 1'b0;
    scan_idx = 0;
    if (mode == LOCKED) begin
      cand  = lock_idx;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N_INPUTS; k++) begin
        scan_idx = (int'(rr_ptr) + k) % N_INPUTS;
        if (!found && bus.in_notEmpty[N_SRC_BITS'(scan_idx)]) begin
          cand  = N_SRC_BITS'(scan_idx);
          found = 1'b1;
        end
      end
    end
  end

  assign cand_eop = bus.in_eop[cand];
  assign fire     = !reset && found && bus.in_notEmpty[cand] && bus.out_notFull;
  assign next_ptr = (cand == N_SRC_BITS'(N_INPUTS - 1)) ? '0 : cand + 1'b1;

  always_comb begin
    bus.out_enq_data = bus.in_first[cand];
    bus.out_eop      = cand_eop;
    bus.out_src      = cand;
    bus.out_enq_en   = fire;
    bus.in_deq_en    = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      bus.in_deq_en[i] = fire && (cand == N_SRC_BITS'(i));
    end
  end

  // Non-eop beats lock the grant; the eop beat releases it and moves priority past the sender.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode     <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else if (fire) begin
      if (cand_eop) begin
        mode   <= IDLE;
        rr_ptr <= next_ptr;
      end else begin
        mode     <= LOCKED;
        lock_idx <= cand;
      end
    end
  end

  a_deq_needs_data: assert property (@(posedge clk) disable iff (reset)
    (bus.in_deq_en & ~bus.in_notEmpty) == '0);
  a_enq_needs_space: assert property (@(posedge clk) disable iff (reset)
    bus.out_enq_en |-> bus.out_notFull);
  a_deq_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.in_deq_en));

endmodule

// File: tb/tb_cci_mpf_prim_rr_merge.sv
// Bench for the round-robin merge: directed vector table, corner sequences, and a
// randomized run against a packet-queue reference model.
module tb_cci_mpf_prim_rr_merge;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cci_mpf_prim_rr_merge_if #(.N_INPUTS(4), .N_DATA_BITS(32)) bus4 ();
  cci_mpf_prim_rr_merge_if #(.N_INPUTS(3), .N_DATA_BITS(32)) bus3 ();

  cci_mpf_prim_rr_merge #(.N_INPUTS(4), .N_DATA_BITS(32)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  cci_mpf_prim_rr_merge #(.N_INPUTS(3), .N_DATA_BITS(32)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3.master)
  );

  int tests = 0;
  int fails = 0;

  // src = -1 means no transfer is expected in that cycle
  typedef struct {
    string      name;
    logic [3:0] ne;
    logic [3:0] eop;
    logic       nf;
    int         src;
  } vec_t;

  vec_t vecs[$];

  logic [2:0] ne3v [6];
  int         exp3 [6];

  logic [32:0]      srcq [4][$];
  logic [3:0][31:0] rdata;
  logic [3:0]       rne;
  logic [3:0]       reop;
  logic             rnf;
  logic [32:0]      head;
  int               owner;
  int               prio;
  int               expSrc;
  int               len;

  task automatic addVec(input string name, input logic [3:0] ne, input logic [3:0] eop,
                        input logic nf, input int src);
    vec_t v;
    v.name = name;
    v.ne   = ne;
    v.eop  = eop;
    v.nf   = nf;
    v.src  = src;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0][31:0] tabData(input int row);
    logic [3:0][31:0] d;
    for (int i = 0; i < 4; i++) d[i] = 32'h1000_0000 + 32'(row * 16 + i);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] ne, input logic [3:0] eop,
                               input logic nf, input logic [3:0][31:0] data, input logic [2:0] ne3);
    @(negedge clk);
    reset            = rst;
    bus4.in_notEmpty = ne;
    bus4.in_eop      = eop;
    bus4.out_notFull = nf;
    bus4.in_first    = data;
    bus3.in_notEmpty = ne3;
    bus3.in_eop      = 3'b111;
    bus3.out_notFull = 1'b1;
    for (int i = 0; i < 3; i++) bus3.in_first[i] = 32'h3000_0000 + 32'(i);
    #1;
  endtask

  task automatic checkDut4(input string name, input int src, input logic [31:0] data, input logic eop);
    logic [3:0] expDeq;
    expDeq = (src >= 0) ? 4'(1 << src) : 4'b0000;
    checkOutput({name, " enq_en"}, 64'(bus4.out_enq_en), 64'(src >= 0));
    checkOutput({name, " deq_en"}, 64'(bus4.in_deq_en), 64'(expDeq));
    if (src >= 0) begin
      checkOutput({name, " src"}, 64'(bus4.out_src), 64'(src));
      checkOutput({name, " data"}, 64'(bus4.out_enq_data), 64'(data));
      checkOutput({name, " eop"}, 64'(bus4.out_eop), 64'(eop));
    end
  endtask

  task automatic checkDut3(input string name, input int src);
    logic [2:0] expDeq;
    expDeq = (src >= 0) ? 3'(1 << src) : 3'b000;
    checkOutput({name, " enq_en"}, 64'(bus3.out_enq_en), 64'(src >= 0));
    checkOutput({name, " deq_en"}, 64'(bus3.in_deq_en), 64'(expDeq));
    if (src >= 0) begin
      checkOutput({name, " src"}, 64'(bus3.out_src), 64'(src));
      checkOutput({name, " data"}, 64'(bus3.out_enq_data), 64'(32'h3000_0000 + 32'(src)));
    end
  endtask

  initial begin
    // Single-beat packets from every input: strict 0,1,2,3 rotation
    addVec("rr0", 4'hF, 4'hF, 1'b1, 0);
    addVec("rr1", 4'hF, 4'hF, 1'b1, 1);
    addVec("rr2", 4'hF, 4'hF, 1'b1, 2);
    addVec("rr3", 4'hF, 4'hF, 1'b1, 3);
    addVec("rr4", 4'hF, 4'hF, 1'b1, 0);
    // Three-beat packet on input 1 with inputs 0 and 2 pending
    addVec("pkt1_b1", 4'b0111, 4'b1101, 1'b1, 1);
    addVec("pkt1_b2", 4'b0111, 4'b1101, 1'b1, 1);
    addVec("pkt1_b3", 4'b0111, 4'b1111, 1'b1, 1);
    addVec("pkt1_next2", 4'b0101, 4'hF, 1'b1, 2);
    addVec("pkt1_next0", 4'b0001, 4'hF, 1'b1, 0);
    // Bubble mid-packet on input 0 while input 3 waits
    addVec("bub_b1", 4'b0001, 4'b1110, 1'b1, 0);
    addVec("bub_gap1", 4'b1000, 4'b1110, 1'b1, -1);
    addVec("bub_gap2", 4'b1000, 4'b1110, 1'b1, -1);
    addVec("bub_b2", 4'b1001, 4'b1110, 1'b1, 0);
    addVec("bub_b3", 4'b1001, 4'b1111, 1'b1, 0);
    addVec("bub_in3", 4'b1000, 4'hF, 1'b1, 3);
    // Downstream backpressure toggling
    addVec("bp0", 4'hF, 4'hF, 1'b1, 0);
    addVec("bp1", 4'hF, 4'hF, 1'b0, -1);
    addVec("bp2", 4'hF, 4'hF, 1'b1, 1);
    addVec("bp3", 4'hF, 4'hF, 1'b0, -1);
    addVec("bp4", 4'hF, 4'hF, 1'b1, 2);
    addVec("bp5", 4'hF, 4'hF, 1'b0, -1);
    addVec("bp6", 4'hF, 4'hF, 1'b1, 3);
    // Higher-priority arrival during a stalled idle cycle wins
    addVec("late_stall", 4'b0100, 4'hF, 1'b0, -1);
    addVec("late_win", 4'b0101, 4'hF, 1'b1, 0);
    // A stall while locked keeps the lock
    addVec("lk_b1", 4'b0100, 4'b1011, 1'b1, 2);
    addVec("lk_stall", 4'hF, 4'b1011, 1'b0, -1);
    addVec("lk_b2", 4'hF, 4'hF, 1'b1, 2);
    addVec("lk_next", 4'hF, 4'hF, 1'b1, 3);

    ne3v = '{3'b100, 3'b101, 3'b100, 3'b100, 3'b111, 3'b111};
    exp3 = '{2, 0, 2, 2, 0, 1};

    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, tabData(0), 3'b111);
    checkDut4("reset_a", -1, 32'h0, 1'b0);
    checkDut3("reset3_a", -1);
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, tabData(0), 3'b111);
    checkDut4("reset_b", -1, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'hF, 1'b1, tabData(0), 3'b000);
    checkDut4("idle_empty", -1, 32'h0, 1'b0);

    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(1'b0, vecs[r].ne, vecs[r].eop, vecs[r].nf, tabData(r), 3'b000);
      checkDut4(vecs[r].name, vecs[r].src,
                32'h1000_0000 + 32'(r * 16 + vecs[r].src),
                (vecs[r].src >= 0) ? vecs[r].eop[vecs[r].src[1:0]] : 1'b0);
    end

    // Reset while input 1 holds the lock abandons the packet and restarts at input 0
    applyStimulus(1'b0, 4'b0010, 4'b1101, 1'b1, tabData(40), 3'b000);
    checkDut4("rst_mid_lock", 1, 32'h1000_0000 + 32'(40 * 16 + 1), 1'b0);
    applyStimulus(1'b1, 4'hF, 4'hF, 1'b1, tabData(41), 3'b000);
    checkDut4("rst_mid_during", -1, 32'h0, 1'b0);
    applyStimulus(1'b0, 4'hF, 4'hF, 1'b1, tabData(42), 3'b000);
    checkDut4("rst_mid_after", 0, 32'h1000_0000 + 32'(42 * 16), 1'b1);

    // Three-input instance: pointer wraps from 2 back to 0
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'b0, 4'h0, 4'hF, 1'b1, tabData(0), ne3v[r]);
      checkDut3($sformatf("wrap3_%0d", r), exp3[r]);
    end

    // Randomized traffic against the packet-queue model
    applyStimulus(1'b1, 4'h0, 4'hF, 1'b1, tabData(0), 3'b000);
    owner = -1;
    prio  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) srcq[i].push_back({(b == len - 1), 32'($urandom)});
        end
        rne[i] = (srcq[i].size() != 0) && ($urandom_range(0, 3) != 0);
        if (srcq[i].size() != 0) begin
          rdata[i] = srcq[i][0][31:0];
          reop[i]  = srcq[i][0][32];
        end else begin
          rdata[i] = 32'($urandom);
          reop[i]  = 1'($urandom);
        end
      end
      rnf = ($urandom_range(0, 3) != 0);

      expSrc = -1;
      if (owner >= 0) begin
        if (rne[owner]) expSrc = owner;
      end else begin
        for (int k = 0; k < 4; k++)
          if (expSrc < 0 && rne[(prio + k) % 4]) expSrc = (prio + k) % 4;
      end
      if (!rnf) expSrc = -1;

      head = (expSrc >= 0) ? srcq[expSrc][0] : 33'h0;
      applyStimulus(1'b0, rne, reop, rnf, rdata, 3'b000);
      checkDut4($sformatf("rand_%0d", cyc), expSrc, head[31:0], head[32]);

      if (expSrc >= 0) begin
        void'(srcq[expSrc].pop_front());
        if (head[32]) begin
          owner = -1;
          prio  = (expSrc + 1) % 4;
        end else begin
          owner = expSrc;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
